// File: rtl/bpu_resolve_queue_if.sv
// Handshake bundle between fetch/BPU, execute and the branch resolve queue.
// The master side issues predictions and resolves; the slave side is the queue.
interface bpu_resolve_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic                       predict_valid_i;
  logic                       predict_taken_i;
  logic [ADDR_W-1:0]          predict_target_i;
  logic [ADDR_W-1:0]          predict_fall_i;
  logic                       predict_ready_o;
  logic                       resolve_valid_i;
  logic                       resolve_taken_i;
  logic                       conditional_jump_o;
  logic                       shouldnt_jump_o;
  logic                       redirect_o;
  logic [ADDR_W-1:0]          redirect_addr_o;
  logic [$clog2(DEPTH+1)-1:0] occupancy_o;
  logic [CNT_W-1:0]           mispredict_cnt_o;
  logic                       underflow_o;

  modport master (
    output predict_valid_i, predict_taken_i, predict_target_i, predict_fall_i,
    output resolve_valid_i, resolve_taken_i,
    input  predict_ready_o, conditional_jump_o, shouldnt_jump_o, redirect_o,
    input  redirect_addr_o, occupancy_o, mispredict_cnt_o, underflow_o
  );

  modport slave (
    input  predict_valid_i, predict_taken_i, predict_target_i, predict_fall_i,
    input  resolve_valid_i, resolve_taken_i,
    output predict_ready_o, conditional_jump_o, shouldnt_jump_o, redirect_o,
    output redirect_addr_o, occupancy_o, mispredict_cnt_o, underflow_o
  );
endinterface

// File: rtl/bpu_resolve_queue.sv
// In-flight conditional-branch prediction queue: holds fetch predictions until execute
// resolves them, emits BPU training pulses and a redirect/flush on a misprediction.
module bpu_resolve_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic               clk_i,
  input  logic               arst_i,
  bpu_resolve_queue_if.slave bq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              taken_mem  [DEPTH];
  logic [ADDR_W-1:0] target_mem [DEPTH];
  logic [ADDR_W-1:0] fall_mem   [DEPTH];

  logic [PTR_W:0]    rd_ptr, wr_ptr;
  logic              full, empty, push, pop, mispredict;
  logic              head_taken;
  logic [ADDR_W-1:0] head_target, head_fall;

  logic              cj_q, sj_q, redirect_q, underflow_q;
  logic [ADDR_W-1:0] redirect_addr_q;
  logic [CNT_W-1:0]  mispredict_cnt_q;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  always_comb begin
    empty       = (rd_ptr == wr_ptr);
    full        = (rd_ptr[PTR_W-1:0] == wr_ptr[PTR_W-1:0]) && (rd_ptr[PTR_W] != wr_ptr[PTR_W]);
    head_taken  = taken_mem[rd_ptr[PTR_W-1:0]];
    head_target = target_mem[rd_ptr[PTR_W-1:0]];
    head_fall   = fall_mem[rd_ptr[PTR_W-1:0]];
    push        = bq.predict_valid_i && !full;
    pop         = bq.resolve_valid_i && !empty;
    mispredict  = pop && (head_taken != bq.resolve_taken_i);
  end

  // A mispredict flush drops any same-cycle enqueue, so the write is suppressed too.
  always_ff @(posedge clk_i) begin
    if (push && !mispredict) begin
      taken_mem[wr_ptr[PTR_W-1:0]]  <= bq.predict_taken_i;
      target_mem[wr_ptr[PTR_W-1:0]] <= bq.predict_target_i;
      fall_mem[wr_ptr[PTR_W-1:0]]   <= bq.predict_fall_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (mispredict) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Training/redirect outputs are registered; the redirect address holds between mispredicts.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      cj_q             <= 1'b0;
      sj_q             <= 1'b0;
      redirect_q       <= 1'b0;
      redirect_addr_q  <= '0;
      mispredict_cnt_q <= '0;
      underflow_q      <= 1'b0;
    end else begin
      cj_q       <= pop;
      sj_q       <= pop && !bq.resolve_taken_i;
      redirect_q <= mispredict;
      if (mispredict) begin
        redirect_addr_q <= bq.resolve_taken_i ? head_target : head_fall;
        if (mispredict_cnt_q != '1) mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
      end
      if (bq.resolve_valid_i && empty) underflow_q <= 1'b1;
    end
  end

  assign bq.predict_ready_o    = !full;
  assign bq.conditional_jump_o = cj_q;
  assign bq.shouldnt_jump_o    = sj_q;
  assign bq.redirect_o         = redirect_q;
  assign bq.redirect_addr_o    = redirect_addr_q;
  assign bq.occupancy_o        = OCC_W'(wr_ptr - rd_ptr);
  assign bq.mispredict_cnt_o   = mispredict_cnt_q;
  assign bq.underflow_o        = underflow_q;
endmodule

// File: tb/tb_bpu_resolve_queue.sv
// Directed bench for bpu_resolve_queue: a DEPTH=4 queue plus a CNT_W=2 instance
// for mispredict-counter saturation; outputs are sampled 1 ns after the rising edge.
module tb_bpu_resolve_queue;
  logic clk_i  = 1'b0;
  logic arst_i = 1'b0;
  int   total  = 0;
  int   bad    = 0;
  int   bpu_ctr = 0;
  bit   track_bpu = 1'b0;

  bpu_resolve_queue_if #(.DEPTH(4), .ADDR_W(16), .CNT_W(16)) bq ();
  bpu_resolve_queue_if #(.DEPTH(4), .ADDR_W(16), .CNT_W(2))  bs ();

  bpu_resolve_queue #(.DEPTH(4), .ADDR_W(16), .CNT_W(16)) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bq     (bq.slave)
  );

  bpu_resolve_queue #(.DEPTH(4), .ADDR_W(16), .CNT_W(2)) dut_sat (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bq     (bs.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle on the main queue, then samples just after the edge;
  // a BPU-style 2-bit counter follows the training pulses when enabled.
  task automatic applyStimulus(input logic pv, input logic pt, input logic [15:0] tgt,
                               input logic [15:0] fall, input logic rv, input logic rt);
    bq.predict_valid_i  = pv;
    bq.predict_taken_i  = pt;
    bq.predict_target_i = tgt;
    bq.predict_fall_i   = fall;
    bq.resolve_valid_i  = rv;
    bq.resolve_taken_i  = rt;
    @(posedge clk_i);
    #1;
    bq.predict_valid_i = 1'b0;
    bq.resolve_valid_i = 1'b0;
    if (track_bpu && bq.conditional_jump_o) begin
      if (bq.shouldnt_jump_o) bpu_ctr = (bpu_ctr > 0) ? bpu_ctr - 1 : 0;
      else                    bpu_ctr = (bpu_ctr < 3) ? bpu_ctr + 1 : 3;
    end
  endtask

  task automatic applySat(input logic pv, input logic pt, input logic rv, input logic rt);
    bs.predict_valid_i  = pv;
    bs.predict_taken_i  = pt;
    bs.predict_target_i = 16'hA000;
    bs.predict_fall_i   = 16'hB000;
    bs.resolve_valid_i  = rv;
    bs.resolve_taken_i  = rt;
    @(posedge clk_i);
    #1;
    bs.predict_valid_i = 1'b0;
    bs.resolve_valid_i = 1'b0;
  endtask

  initial begin
    bq.predict_valid_i = 1'b0; bq.predict_taken_i = 1'b0;
    bq.predict_target_i = '0;  bq.predict_fall_i = '0;
    bq.resolve_valid_i = 1'b0; bq.resolve_taken_i = 1'b0;
    bs.predict_valid_i = 1'b0; bs.predict_taken_i = 1'b0;
    bs.predict_target_i = '0;  bs.predict_fall_i = '0;
    bs.resolve_valid_i = 1'b0; bs.resolve_taken_i = 1'b0;

    #12;
    checkOutput("rst_occ",   bq.occupancy_o, 0);
    checkOutput("rst_ready", bq.predict_ready_o, 1);
    checkOutput("rst_cj",    bq.conditional_jump_o, 0);
    checkOutput("rst_redir", bq.redirect_o, 0);
    checkOutput("rst_cnt",   bq.mispredict_cnt_o, 0);
    checkOutput("rst_uflow", bq.underflow_o, 0);
    @(negedge clk_i);
    arst_i = 1'b1;
    checkOutput("rel_ready", bq.predict_ready_o, 1);

    // Fill to DEPTH; the fifth prediction must be dropped.
    applyStimulus(1, 1, 16'h0100, 16'h0104, 0, 0);
    applyStimulus(1, 1, 16'h0200, 16'h0204, 0, 0);
    applyStimulus(1, 0, 16'h0300, 16'h0304, 0, 0);
    applyStimulus(1, 1, 16'h0400, 16'h0404, 0, 0);
    checkOutput("full_occ",   bq.occupancy_o, 4);
    checkOutput("full_ready", bq.predict_ready_o, 0);
    applyStimulus(1, 0, 16'h0F00, 16'h0F04, 0, 0);
    checkOutput("drop5_occ",  bq.occupancy_o, 4);

    // Full with same-cycle pop: the push still loses; head {T,0x0100} resolves taken.
    applyStimulus(1, 0, 16'h0500, 16'h0504, 1, 1);
    checkOutput("pop_full_occ", bq.occupancy_o, 3);
    checkOutput("res_t_cj",     bq.conditional_jump_o, 1);
    checkOutput("res_t_sj",     bq.shouldnt_jump_o, 0);
    checkOutput("res_t_redir",  bq.redirect_o, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("res2_occ",     bq.occupancy_o, 2);
    checkOutput("res2_cnt",     bq.mispredict_cnt_o, 0);

    // Enqueue plus correct not-taken resolve of {N,0x0300}: occupancy unchanged.
    applyStimulus(1, 1, 16'h0600, 16'h0604, 1, 0);
    checkOutput("simul_occ",   bq.occupancy_o, 2);
    checkOutput("simul_sj",    bq.shouldnt_jump_o, 1);
    checkOutput("simul_redir", bq.redirect_o, 0);
    checkOutput("simul_addr",  bq.redirect_addr_o, 16'h0000);

    // Head {T,fall=0x0404} resolves not-taken: redirect, flush, same-cycle push lost.
    applyStimulus(1, 1, 16'h0700, 16'h0704, 0, 0);
    checkOutput("pre_mis_occ", bq.occupancy_o, 3);
    applyStimulus(1, 0, 16'h0800, 16'h0804, 1, 0);
    checkOutput("mis_redir", bq.redirect_o, 1);
    checkOutput("mis_addr",  bq.redirect_addr_o, 16'h0404);
    checkOutput("mis_sj",    bq.shouldnt_jump_o, 1);
    checkOutput("mis_cj",    bq.conditional_jump_o, 1);
    checkOutput("mis_occ",   bq.occupancy_o, 0);
    checkOutput("mis_cnt",   bq.mispredict_cnt_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("idle_redir", bq.redirect_o, 0);
    checkOutput("idle_cj",    bq.conditional_jump_o, 0);
    checkOutput("hold_addr",  bq.redirect_addr_o, 16'h0404);

    // Resolve while empty is ignored but leaves the sticky underflow flag.
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("uf_cj",   bq.conditional_jump_o, 0);
    checkOutput("uf_flag", bq.underflow_o, 1);
    checkOutput("uf_occ",  bq.occupancy_o, 0);
    applyStimulus(1, 1, 16'h0900, 16'h0904, 1, 1);
    checkOutput("uf_push_occ", bq.occupancy_o, 1);
    checkOutput("uf_push_cj",  bq.conditional_jump_o, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("uf_pop_cj",    bq.conditional_jump_o, 1);
    checkOutput("uf_pop_occ",   bq.occupancy_o, 0);
    checkOutput("uf_sticky",    bq.underflow_o, 1);

    // Twelve push/resolve pairs wrap the pointers three times; BPU counter starts weak-taken.
    bpu_ctr   = 2;
    track_bpu = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic dir;
      dir = (i % 3) != 0;
      applyStimulus(1, dir, 16'(16'h1000 + i), 16'(16'h2000 + i), 0, 0);
      checkOutput($sformatf("wrap_push_occ%0d", i), bq.occupancy_o, 1);
      applyStimulus(0, 0, 0, 0, 1, dir);
      checkOutput($sformatf("wrap_sj%0d", i), bq.shouldnt_jump_o, !dir);
      checkOutput($sformatf("wrap_occ%0d", i), bq.occupancy_o, 0);
    end
    applyStimulus(1, 1, 16'h1234, 16'h5678, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    track_bpu = 1'b0;
    checkOutput("wrap_mis_addr", bq.redirect_addr_o, 16'h5678);
    checkOutput("wrap_mis_cnt",  bq.mispredict_cnt_o, 2);
    checkOutput("bpu_ctr",       bpu_ctr, 2);

    // Asynchronous reset mid-operation clears a live redirect pulse immediately.
    applyStimulus(1, 0, 16'h3000, 16'h3004, 0, 0);
    applyStimulus(1, 1, 16'h3100, 16'h3104, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("pre_rst_redir", bq.redirect_o, 1);
    checkOutput("pre_rst_addr",  bq.redirect_addr_o, 16'h3000);
    #2;
    arst_i = 1'b0;
    #1;
    checkOutput("arst_redir", bq.redirect_o, 0);
    checkOutput("arst_occ",   bq.occupancy_o, 0);
    checkOutput("arst_uflow", bq.underflow_o, 0);
    checkOutput("arst_cnt",   bq.mispredict_cnt_o, 0);
    @(negedge clk_i);
    arst_i = 1'b1;

    // CNT_W=2 instance: four mispredicts saturate at 3.
    for (int i = 0; i < 4; i++) begin
      applySat(1, 1, 0, 0);
      applySat(0, 0, 1, 0);
      checkOutput($sformatf("sat_cnt%0d", i), bs.mispredict_cnt_o, (i < 3) ? i + 1 : 3);
    end
    checkOutput("sat_redir", bs.redirect_o, 1);
    checkOutput("sat_addr",  bs.redirect_addr_o, 16'hB000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
